// File: rtl/taxi_i2c_master_apb_regs_if.sv
// APB completer and AXI-Stream interfaces used by the I2C master register block.

interface taxi_apb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport mst (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slv (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8,
    parameter int USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_i2c_master_apb_regs.sv
// APB register front-end for an I2C master: one-deep command, tx and rx holding
// registers, sticky status flags and prescale / stop-on-idle control.

module taxi_i2c_master_apb_regs (
    input  logic        clk,
    input  logic        rst,
    taxi_apb_if.slv     s_apb,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    taxi_axis_if.src    m_axis_tx,
    taxi_axis_if.snk    s_axis_rx,
    input  logic        i2c_busy,
    input  logic        i2c_bus_control,
    input  logic        i2c_bus_active,
    input  logic        i2c_missed_ack,
    output logic [15:0] prescale,
    output logic        stop_on_idle
);
    localparam int APB_DATA_W = s_apb.DATA_W;
    localparam int APB_ADDR_W = s_apb.ADDR_W;
    localparam int APB_STRB_W = s_apb.STRB_W;
    localparam int TX_DATA_W  = m_axis_tx.DATA_W;
    localparam int RX_DATA_W  = s_axis_rx.DATA_W;

    if (APB_DATA_W != 32 || APB_STRB_W != 4 || APB_ADDR_W < 4) begin : g_bad_apb
        $fatal(0, "APB interface must have DATA_W=32, STRB_W=4 and ADDR_W>=4");
    end
    if (TX_DATA_W != 8 || RX_DATA_W != 8) begin : g_bad_axis
        $fatal(0, "AXI-Stream interfaces must have DATA_W=8");
    end

    logic        pready_reg;
    logic [31:0] prdata_reg;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  reg_sel;
    logic        access;
    logic        wr_access;
    logic        status_wr;
    logic        cmd_wr;
    logic        cmd_drop;
    logic        tx_wr;
    logic        tx_drop;
    logic        ctrl_wr;
    logic        rx_pop;
    logic        rx_capture;

    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        rx_valid;
    logic        missed_ack;
    logic        cmd_overflow;
    logic        tx_overflow;

    // Access is sampled once per transfer: the edge that raises pready is the
    // only edge where register side effects take place.
    assign access     = s_apb.psel && s_apb.penable && !pready_reg;
    assign wr_access  = access && s_apb.pwrite;
    assign wdata      = s_apb.pwdata;
    assign strb       = s_apb.pstrb;
    assign reg_sel    = s_apb.paddr[3:2];

    assign status_wr  = wr_access && reg_sel == 2'd0;
    assign cmd_wr     = wr_access && reg_sel == 2'd1 && strb[0] && |wdata[12:8];
    assign cmd_drop   = cmd_wr && cmd_valid;
    assign tx_wr      = wr_access && reg_sel == 2'd2 && strb[0];
    assign tx_drop    = tx_wr && tx_valid;
    assign ctrl_wr    = wr_access && reg_sel == 2'd3;
    assign rx_pop     = access && !s_apb.pwrite && reg_sel == 2'd2 && rx_valid;
    assign rx_capture = s_axis_rx.tvalid && !rx_valid;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = {21'd0, rx_valid, tx_valid, cmd_valid, 2'd0, tx_overflow,
                           cmd_overflow, missed_ack, i2c_bus_active, i2c_bus_control, i2c_busy};
            2'd1: rdata = {19'd0, cmd_stop, cmd_write_multiple, cmd_write, cmd_read,
                           cmd_start, 1'b0, cmd_address};
            2'd2: rdata = rx_valid ? {22'd0, rx_last, 1'b1, rx_data} : '0;
            default: rdata = {15'd0, stop_on_idle, prescale};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pready_reg         <= 1'b0;
            prdata_reg         <= '0;
            cmd_address        <= '0;
            cmd_start          <= 1'b0;
            cmd_read           <= 1'b0;
            cmd_write          <= 1'b0;
            cmd_write_multiple <= 1'b0;
            cmd_stop           <= 1'b0;
            cmd_valid          <= 1'b0;
            tx_data            <= '0;
            tx_last            <= 1'b0;
            tx_valid           <= 1'b0;
            rx_data            <= '0;
            rx_last            <= 1'b0;
            rx_valid           <= 1'b0;
            missed_ack         <= 1'b0;
            cmd_overflow       <= 1'b0;
            tx_overflow        <= 1'b0;
            prescale           <= '0;
            stop_on_idle       <= 1'b0;
        end else begin
            pready_reg <= access;
            prdata_reg <= (access && !s_apb.pwrite) ? rdata : '0;

            // Set events take priority over a simultaneous write-one-to-clear.
            missed_ack   <= i2c_missed_ack || (missed_ack && !(status_wr && wdata[3]));
            cmd_overflow <= cmd_drop || (cmd_overflow && !(status_wr && wdata[4]));
            tx_overflow  <= tx_drop || (tx_overflow && !(status_wr && wdata[5]));

            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end else if (cmd_wr && !cmd_valid) begin
                cmd_address        <= wdata[6:0];
                cmd_start          <= wdata[8];
                cmd_read           <= wdata[9];
                cmd_write          <= wdata[10];
                cmd_write_multiple <= wdata[11];
                cmd_stop           <= wdata[12];
                cmd_valid          <= 1'b1;
            end

            if (tx_valid && m_axis_tx.tready) begin
                tx_valid <= 1'b0;
            end else if (tx_wr && !tx_valid) begin
                tx_data  <= wdata[7:0];
                tx_last  <= wdata[9];
                tx_valid <= 1'b1;
            end

            // rx_valid gates tready, so a pop and a capture can never coincide.
            if (rx_pop) begin
                rx_valid <= 1'b0;
            end else if (rx_capture) begin
                rx_data  <= s_axis_rx.tdata;
                rx_last  <= s_axis_rx.tlast;
                rx_valid <= 1'b1;
            end

            if (ctrl_wr) begin
                if (strb[0]) prescale[7:0]  <= wdata[7:0];
                if (strb[1]) prescale[15:8] <= wdata[15:8];
                if (strb[2]) stop_on_idle   <= wdata[16];
            end
        end
    end

    assign s_apb.pready   = pready_reg;
    assign s_apb.prdata   = prdata_reg;
    assign s_apb.pslverr  = 1'b0;

    assign m_axis_tx.tdata  = tx_data;
    assign m_axis_tx.tlast  = tx_last;
    assign m_axis_tx.tvalid = tx_valid;
    assign m_axis_tx.tkeep  = '0;
    assign m_axis_tx.tid    = '0;
    assign m_axis_tx.tdest  = '0;
    assign m_axis_tx.tuser  = '0;

    assign s_axis_rx.tready = !rx_valid;

    logic unused_sink;
    assign unused_sink = ^{s_apb.paddr, s_apb.pwdata, s_apb.pstrb, s_axis_rx.tkeep,
                           s_axis_rx.tid, s_axis_rx.tdest, s_axis_rx.tuser};

endmodule

// File: doc/taxi_i2c_master_apb_regs.md
TAXI_I2C_MASTER_APB_REGS -- requirements
Module: taxi_i2c_master_apb_regs

Interface
REQ-001 Parameters: none. APB widths come from s_apb: DATA_W = 32, ADDR_W >= 4, STRB_W = 4; any other width SHALL $fatal at elaboration.
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s_apb  taxi_apb_if.slv  --  APB completer; host register access.
REQ-005 cmd_address / cmd_start / cmd_read / cmd_write / cmd_write_multiple / cmd_stop  output  7/1/1/1/1/1  I2C master command fields.
REQ-006 cmd_valid  output  1  command valid.
REQ-007 cmd_ready  input  1  command accepted.
REQ-008 m_axis_tx  taxi_axis_if.src (DATA_W=8)  --  write data to I2C master.
REQ-009 s_axis_rx  taxi_axis_if.snk (DATA_W=8)  --  read data from I2C master.
REQ-010 i2c_busy / i2c_bus_control / i2c_bus_active / i2c_missed_ack  input  1 each  I2C master status.
REQ-011 prescale  output  16  I2C bit-rate prescale.
REQ-012 stop_on_idle  output  1  I2C master auto-stop enable.

Function
REQ-013 APB timing: setup phase (psel, !penable) -> access phase; pready SHALL assert for exactly one cycle, on the second access-phase cycle (registered). Every transfer therefore takes 3 cycles.
REQ-014 Register decode SHALL use paddr[3:2]. prdata SHALL be valid only while pready=1 and SHALL be 0 otherwise. pslverr SHALL be 0 for all four offsets.
REQ-015 0x0 STATUS (read only): [0] i2c_busy, [1] i2c_bus_control, [2] i2c_bus_active, [3] missed_ack (sticky), [4] cmd_overflow (sticky), [5] tx_overflow (sticky), [8] cmd_full, [9] tx_full, [10] rx_valid. Writing 1 to [5:3] SHALL clear that sticky bit; a write of 0 SHALL leave it unchanged.
REQ-016 Sticky bits SHALL set on i2c_missed_ack=1 or on an overflow event. If a set event and a W1C occur in the same cycle, set SHALL win.
REQ-017 0x4 CMD (write): [6:0] address, [8] start, [9] read, [10] write, [11] write_multiple, [12] stop.
  - The write SHALL load a one-entry command holding register and set cmd_valid=1, but only if any of bits [12:8] is 1.
  - If cmd_valid is already 1, the write SHALL be dropped and cmd_overflow set.
  - Reading 0x4 SHALL return the holding-register contents.
REQ-018 cmd_valid SHALL clear on the cycle after cmd_valid && cmd_ready. cmd_full = cmd_valid.
REQ-019 0x8 DATA write: [7:0] -> m_axis_tx.tdata, [9] -> m_axis_tx.tlast, then tvalid=1.
  - If tvalid is already 1, the write SHALL be dropped and tx_overflow set.
  - tvalid SHALL clear after the tvalid && tready handshake. tx_full = tvalid.
  - tid, tdest, tuser and tkeep SHALL be tied to 0.
REQ-020 s_axis_rx SHALL be captured into a one-entry rx register: tready = !rx_valid.
REQ-021 0x8 DATA read: returns [7:0] rx data, [8] rx_valid, [9] rx last.
  - When rx_valid=1, the read SHALL clear rx_valid in its pready cycle (pop).
  - A read with rx_valid=0 SHALL return 0 and have no side effect.
  - A pop and a new capture SHALL NOT occur in the same cycle.
REQ-022 0xC CTRL (read/write): [15:0] prescale, [16] stop_on_idle. Byte writes SHALL follow pstrb.
  - For 0x4 and 0x8, a write SHALL take effect only if pstrb[0]=1.
REQ-023 All side effects SHALL occur exactly once per transfer, in the pready cycle.
REQ-024 A setup phase with no access phase following (psel dropped) SHALL be ignored.

Reset
REQ-025 On rst=1, on the next clock:
  - pready, cmd_valid, m_axis_tx.tvalid, rx_valid, all sticky bits and stop_on_idle SHALL be 0.
  - prescale SHALL be 0; s_axis_rx.tready SHALL be 1 from the following cycle.
  - Command holding-register fields SHALL be 0.
REQ-026 A reset asserted mid-APB-transfer SHALL abort it with no side effect. The bench SHALL restart with a new setup phase.

Verification
REQ-027 Write 0xC = 0x0001_0040 with pstrb=0xF -> prescale=0x0040, stop_on_idle=1; read back 0x0001_0040; pready seen exactly 2 cycles after the setup cycle.
REQ-028 Write 0x4 = 0x1550 (addr 0x50, start+write+stop) with cmd_ready=0 -> cmd_valid=1; second write -> STATUS[4]=1 and fields unchanged; cmd_ready=1 -> cmd_valid=0 next cycle.
REQ-029 Write 0x8 = 0x2A5 -> tdata=0xA5, tlast=1, tvalid=1 held until tready; STATUS[9] tracks it.
REQ-030 Present rx byte 0x3C with tlast=1 -> tready falls; read 0x8 returns 0x33C; next read returns 0; tready=1 again.
REQ-031 Pulse i2c_missed_ack -> STATUS[3]=1; write STATUS=0x8 in the same cycle as a new pulse -> bit stays 1; write again with no pulse -> 0.
REQ-032 Assert rst during the access phase of a CMD write -> cmd_valid=0 and no pready; a subsequent normal transfer completes correctly.
